// File: rtl/harmonic_note_player.sv
// Plays one note as a weighted sum of NUM_HARMONICS harmonics by sharing one sine ROM port.
// Optional output clamping: define HARMONIC_SAT_EN; otherwise the mix wraps to 16 bits.
module harmonic_note_player #(
  parameter int NUM_HARMONICS = 4,
  parameter int PHASE_W       = 20,
  parameter int SINE_ADDR_W   = 10,
  parameter int STEP_W        = 20
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   play_enable,
  input  logic [5:0]             note_to_load,
  input  logic [5:0]             duration_to_load,
  input  logic                   load_new_note,
  output logic                   done_with_note,
  input  logic                   beat,
  input  logic                   generate_next_sample,
  output logic [5:0]             step_addr,
  input  logic [STEP_W-1:0]      step_data,
  output logic [SINE_ADDR_W-1:0] sine_addr,
  input  logic signed [15:0]     sine_data,
  output logic signed [15:0]     sample_out,
  output logic                   new_sample_ready
);

  localparam int ACC_W = 16 + $clog2(NUM_HARMONICS) + 1;
  localparam int H_W   = (NUM_HARMONICS > 1) ? $clog2(NUM_HARMONICS) : 1;
  localparam logic [H_W-1:0] H_LAST = H_W'(NUM_HARMONICS - 1);
  localparam logic signed [ACC_W-1:0] MAX16 = 32767;
  localparam logic signed [ACC_W-1:0] MIN16 = -32768;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [H_W-1:0]          h_q, h_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0]      phase_q [NUM_HARMONICS];
  logic [PHASE_W-1:0]      phase_d [NUM_HARMONICS];
  logic [5:0]              note_q, note_d, dur_q, dur_d;
  logic                    done_q, done_d, loaded_q, loaded_d;
  logic                    pend_q, pend_d;
  logic [5:0]              pend_note_q, pend_note_d, pend_dur_q, pend_dur_d;
  logic [15:0]             sample_q, sample_d;
  logic                    ready_q, ready_d;

  logic                    running;
  logic signed [ACC_W-1:0] term, acc_sum;
  logic                    apply_load;
  logic [5:0]              load_note, load_dur;

  function automatic logic [15:0] sat16(input logic signed [ACC_W-1:0] v);
`ifdef HARMONIC_SAT_EN
    if (v > MAX16)      return 16'h7FFF;
    else if (v < MIN16) return 16'h8000;
    else                return v[15:0];
`else
    return v[15:0];
`endif
  endfunction

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    acc_d       = acc_q;
    phase_d     = phase_q;
    note_d      = note_q;
    dur_d       = dur_q;
    done_d      = done_q;
    loaded_d    = loaded_q;
    pend_d      = pend_q;
    pend_note_d = pend_note_q;
    pend_dur_d  = pend_dur_q;
    sample_d    = sample_q;
    ready_d     = 1'b0;
    apply_load  = 1'b0;
    load_note   = note_to_load;
    load_dur    = duration_to_load;

    running = play_enable && (note_q != 6'd0) && (dur_q != 6'd0);
    term    = $signed(ACC_W'(sine_data)) >>> h_q;
    acc_sum = acc_q + term;

    case (state_q)
      S_IDLE: begin
        if (generate_next_sample) begin
          state_d = S_ADDR;
          h_d     = '0;
          acc_d   = '0;
        end
      end
      S_ADDR: state_d = S_DATA;
      S_DATA: begin
        acc_d = running ? acc_sum : '0;
        if (h_q == H_LAST) begin
          state_d  = S_DONE;
          sample_d = sat16(acc_d);
          ready_d  = 1'b1;
        end else begin
          state_d = S_ADDR;
          h_d     = h_q + H_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (running) begin
          for (int k = 0; k < NUM_HARMONICS; k++)
            phase_d[k] = phase_q[k] + PHASE_W'(k + 1) * PHASE_W'(step_data);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A load arriving mid-sample waits so the in-flight sample finishes on the old note.
    if (state_q == S_DONE) pend_d = 1'b0;
    if (load_new_note && (state_q == S_IDLE || state_q == S_DONE)) begin
      apply_load = 1'b1;
    end else if (load_new_note) begin
      pend_d      = 1'b1;
      pend_note_d = note_to_load;
      pend_dur_d  = duration_to_load;
    end else if (state_q == S_DONE && pend_q) begin
      apply_load = 1'b1;
      load_note  = pend_note_q;
      load_dur   = pend_dur_q;
    end

    if (apply_load) begin
      note_d   = load_note;
      dur_d    = load_dur;
      done_d   = 1'b0;
      loaded_d = 1'b1;
      for (int k = 0; k < NUM_HARMONICS; k++) phase_d[k] = '0;
    end else begin
      if (beat && play_enable && dur_q != 6'd0) dur_d = dur_q - 6'd1;
      if (loaded_q && dur_q == 6'd0) done_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      h_q         <= '0;
      acc_q       <= '0;
      note_q      <= '0;
      dur_q       <= '0;
      done_q      <= 1'b0;
      loaded_q    <= 1'b0;
      pend_q      <= 1'b0;
      pend_note_q <= '0;
      pend_dur_q  <= '0;
      sample_q    <= '0;
      ready_q     <= 1'b0;
      // NOTE: the phase array is reset because playback must start from phase 0; it is small flops, not RAM.
      for (int k = 0; k < NUM_HARMONICS; k++) phase_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      acc_q       <= acc_d;
      note_q      <= note_d;
      dur_q       <= dur_d;
      done_q      <= done_d;
      loaded_q    <= loaded_d;
      pend_q      <= pend_d;
      pend_note_q <= pend_note_d;
      pend_dur_q  <= pend_dur_d;
      sample_q    <= sample_d;
      ready_q     <= ready_d;
      for (int k = 0; k < NUM_HARMONICS; k++) phase_q[k] <= phase_d[k];
    end
  end

  assign sine_addr        = (state_q == S_ADDR) ? phase_q[h_q][PHASE_W-1 -: SINE_ADDR_W] : '0;
  assign step_addr        = note_q;
  assign done_with_note   = done_q;
  assign sample_out       = sample_q;
  assign new_sample_ready = ready_q;

endmodule

// File: tb/tb_harmonic_note_player.sv
// Directed bench for harmonic_note_player: reset abort, harmonic mixing, request dropping,
// beat-timed duration, deferred loads and output wrap/saturation (follows HARMONIC_SAT_EN).
`timescale 1ns/1ps
module tb_harmonic_note_player;
  localparam int N = 4;

  logic        clk = 1'b0, reset_n = 1'b0, play_enable = 1'b0;
  logic        load_new_note = 1'b0, beat = 1'b0, generate_next_sample = 1'b0;
  logic [5:0]  note_to_load = '0, duration_to_load = '0;
  logic        done_with_note, new_sample_ready;
  logic [5:0]  step_addr;
  logic [19:0] step_data;
  logic [9:0]  sine_addr;
  logic [15:0] sine_data, sample_out;
  bit          force_max = 1'b0;

  int total = 0, bad = 0;
  logic [19:0] m_phase [N];
  logic [5:0]  m_note = '0, m_dur = '0;

  harmonic_note_player dut (
    .clk(clk), .reset_n(reset_n), .play_enable(play_enable),
    .note_to_load(note_to_load), .duration_to_load(duration_to_load),
    .load_new_note(load_new_note), .done_with_note(done_with_note), .beat(beat),
    .generate_next_sample(generate_next_sample), .step_addr(step_addr), .step_data(step_data),
    .sine_addr(sine_addr), .sine_data(sine_data), .sample_out(sample_out),
    .new_sample_ready(new_sample_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] sine_fn(input logic [9:0] a);
    return {a, 6'b010101};
  endfunction

  assign step_data = 20'(step_addr) * 20'd1000;
  always @(posedge clk) sine_data <= force_max ? 16'h7FFF : sine_fn(sine_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [5:0] n, input logic [5:0] d, input bit with_beat);
    note_to_load = n; duration_to_load = d; load_new_note = 1'b1; beat = with_beat;
    tick(1);
    load_new_note = 1'b0; beat = 1'b0;
    m_note = n; m_dur = d;
    for (int k = 0; k < N; k++) m_phase[k] = '0;
  endtask

  task automatic do_beat();
    beat = 1'b1;
    tick(1);
    beat = 1'b0;
    if (play_enable && m_dur != 6'd0) m_dur = m_dur - 6'd1;
    tick(1);
  endtask

  // One request; checks latency, every sine address, the mixed sample and the strobe width.
  task automatic run_sample(input string tag, input bit mid_load, input logic [5:0] ln,
                            input logic [5:0] ld, output logic done_at_strobe);
    logic signed [19:0] acc, t;
    logic [15:0] exp_s, sval;
    logic [9:0]  ea;
    bit          running;
    int          n, h;
    running = play_enable && m_note != 6'd0 && m_dur != 6'd0;
    acc = '0;
    note_to_load = ln; duration_to_load = ld;
    generate_next_sample = 1'b1;
    tick(1);
    generate_next_sample = 1'b0;
    n = 1;
    while (new_sample_ready !== 1'b1 && n < 30) begin
      if (n % 2 == 1 && n < 2 * N) begin
        h  = (n + 1) / 2;
        ea = m_phase[h-1][19:10];
        check({tag, "_addr"}, 32'(sine_addr), 32'(ea));
        sval = force_max ? 16'h7FFF : sine_fn(ea);
        t = 20'($signed(sval));
        t = t >>> (h - 1);
        if (running) acc = acc + t;
      end
      load_new_note = (mid_load && n == 4);
      tick(1);
      load_new_note = 1'b0;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(2 * N + 1));
`ifdef HARMONIC_SAT_EN
    if (acc > 32767)       exp_s = 16'h7FFF;
    else if (acc < -32768) exp_s = 16'h8000;
    else                   exp_s = acc[15:0];
`else
    exp_s = acc[15:0];
`endif
    check({tag, "_sample"}, 32'(sample_out), 32'(exp_s));
    done_at_strobe = done_with_note;
    if (mid_load) begin
      m_note = ln; m_dur = ld;
      for (int k = 0; k < N; k++) m_phase[k] = '0;
    end else if (running) begin
      for (int k = 0; k < N; k++) m_phase[k] = m_phase[k] + 20'(k + 1) * (20'(m_note) * 20'd1000);
    end
    tick(1);
    check({tag, "_strobe_low"}, 32'(new_sample_ready), 32'd0);
  endtask

  initial begin
    logic d;
    int cnt, last, first;
    for (int k = 0; k < N; k++) m_phase[k] = '0;

    // Reset state
    tick(2);
    check("rst_sample", 32'(sample_out), 32'd0);
    check("rst_ready", 32'(new_sample_ready), 32'd0);
    check("rst_done", 32'(done_with_note), 32'd0);
    check("rst_step_addr", 32'(step_addr), 32'd0);
    check("rst_sine_addr", 32'(sine_addr), 32'd0);
    reset_n = 1'b1;
    tick(1);

    // Reset in the middle of a sample aborts it
    play_enable = 1'b1;
    load(6'd57, 6'd5, 1'b0);
    run_sample("t1_pre", 1'b0, 6'd0, 6'd0, d);
    check("t1_pre_nonzero", 32'(sample_out != 16'd0), 32'd1);
    generate_next_sample = 1'b1;
    tick(1);
    generate_next_sample = 1'b0;
    tick(2);
    reset_n = 1'b0;
    #1;
    check("t1_sample", 32'(sample_out), 32'd0);
    check("t1_ready", 32'(new_sample_ready), 32'd0);
    check("t1_done", 32'(done_with_note), 32'd0);
    check("t1_step_addr", 32'(step_addr), 32'd0);
    tick(2);
    reset_n = 1'b1;
    m_note = '0; m_dur = '0;
    for (int k = 0; k < N; k++) m_phase[k] = '0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (new_sample_ready === 1'b1) cnt++;
    end
    check("t1_no_strobe", 32'(cnt), 32'd0);

    // Note 57 over three samples; phases advance by h*step between them
    load(6'd57, 6'd5, 1'b0);
    check("t2_step_addr", 32'(step_addr), 32'd57);
    run_sample("t2_s1", 1'b0, 6'd0, 6'd0, d);
    check("t2_s1_value", 32'(sample_out), 32'h0026);
    run_sample("t2_s2", 1'b0, 6'd0, 6'd0, d);
    run_sample("t2_s3", 1'b0, 6'd0, 6'd0, d);

    // Requests every other cycle: only those arriving in IDLE are taken
    cnt = 0; last = -1; first = -1;
    for (int i = 0; i < 40; i++) begin
      generate_next_sample = (i % 2 == 0);
      tick(1);
      if (new_sample_ready === 1'b1) begin
        if (cnt > 0) check("t3_gap", 32'(i - last), 32'(2 * N + 2));
        else first = i;
        last = i;
        cnt++;
      end
    end
    generate_next_sample = 1'b0;
    check("t3_count", 32'(cnt), 32'd4);
    check("t3_first", 32'(first), 32'(2 * N));
    tick(2);

    // Beat-timed duration, paused beats ignored, silence after expiry
    load(6'd57, 6'd5, 1'b0);
    repeat (4) do_beat();
    play_enable = 1'b0;
    do_beat();
    do_beat();
    check("t4_done_paused", 32'(done_with_note), 32'd0);
    run_sample("t4_pause", 1'b0, 6'd0, 6'd0, d);
    check("t4_pause_zero", 32'(sample_out), 32'd0);
    play_enable = 1'b1;
    beat = 1'b1;
    tick(1);
    beat = 1'b0;
    m_dur = '0;
    check("t4_done_early", 32'(done_with_note), 32'd0);
    tick(1);
    check("t4_done_rise", 32'(done_with_note), 32'd1);
    run_sample("t4_expired", 1'b0, 6'd0, 6'd0, d);
    check("t4_expired_zero", 32'(sample_out), 32'd0);
    check("t4_done_held", 32'(done_with_note), 32'd1);

    // Deferred load: done stays set until DONE, then note 1 starts from phase 0
    load(6'd57, 6'd0, 1'b0);
    tick(1);
    check("t5_done_zero_dur", 32'(done_with_note), 32'd1);
    run_sample("t5a", 1'b1, 6'd1, 6'd8, d);
    check("t5a_done_at_strobe", 32'(d), 32'd1);
    check("t5a_done_cleared", 32'(done_with_note), 32'd0);
    check("t5a_step_addr", 32'(step_addr), 32'd1);
    run_sample("t5b", 1'b0, 6'd0, 6'd0, d);
    run_sample("t5c", 1'b0, 6'd0, 6'd0, d);
    load(6'd57, 6'd5, 1'b0);
    run_sample("t5d", 1'b0, 6'd0, 6'd0, d);
    run_sample("t5e_old_note", 1'b1, 6'd1, 6'd8, d);
    run_sample("t5f_new_note", 1'b0, 6'd0, 6'd0, d);
    load(6'd1, 6'd8, 1'b1);
    repeat (7) do_beat();
    tick(2);
    check("t5_beat_dropped", 32'(done_with_note), 32'd0);
    do_beat();
    check("t5_dur8_done", 32'(done_with_note), 32'd1);

    // Full-scale sine on every harmonic
    force_max = 1'b1;
    load(6'd57, 6'd5, 1'b0);
    run_sample("t6", 1'b0, 6'd0, 6'd0, d);
`ifdef HARMONIC_SAT_EN
    check("t6_const", 32'(sample_out), 32'h7FFF);
`else
    check("t6_const", 32'(sample_out), 32'hEFFC);
`endif
    force_max = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
